main_fifo_ctrl: RTL and testbench

Controller for the Main conditional FIFO in the traffic-class / virtual-channel path. It configures the FIFO's low/high thresholds, pops words while downstream space exists, and routes each word to VC0 or VC1 by a class bit. It also latches any FIFO error into a sticky error state. It sits between the Main FIFO instance and the two VC FIFO write ports.

---
 rtl/main_fifo_ctrl.sv | 179 +++++++++++++++++
 tb/tb_main_fifo_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// main_fifo_ctrl
// Controller for the Main conditional FIFO of the traffic-class / VC path.
// Programs the Main FIFO low/high thresholds, pops words while both VC FIFOs
// have room, and steers each popped word to VC0 or VC1 by one class bit.
// Any FIFO error latches a sticky ERROR state that only reset can clear.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   init                            request threshold (re)configuration
//   umbral_low_in/umbral_high_in    thresholds to program (LEN4 bits)
//   Main_empty/Main_error           Main FIFO status
//   Main_data_out                   Main FIFO read data (valid after Main_rd)
//   VC0/VC1_almost_full, _error     downstream backpressure and errors
//   Main_rd                         combinational pop strobe to the Main FIFO
//   UmbralMF_LOW/UmbralMF_HIGH      registered thresholds to the Main FIFO
//   VC0_wr/VC1_wr, VC_data          registered VC write strobes and data
//   state, idle, error_out          registered FSM status
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module main_fifo_ctrl #(
    parameter int BW     = 6,
    parameter int LEN4   = 4,
    parameter int VC_BIT = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            init,
    input  logic [LEN4-1:0] umbral_low_in,
    input  logic [LEN4-1:0] umbral_high_in,
    input  logic            Main_empty,
    input  logic            Main_error,
    input  logic [BW-1:0]   Main_data_out,
    input  logic            VC0_almost_full,
    input  logic            VC1_almost_full,
    input  logic            VC0_error,
    input  logic            VC1_error,
    output logic            Main_rd,
    output logic [LEN4-1:0] UmbralMF_LOW,
    output logic [LEN4-1:0] UmbralMF_HIGH,
    output logic            VC0_wr,
    output logic            VC1_wr,
    output logic [BW-1:0]   VC_data,
    output logic [2:0]      state,
    output logic            idle,
    output logic            error_out
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_err;
    logic              w_rd;
    logic              r_rd_q;      // a word was popped last cycle; its data is on Main_data_out now
    logic [LEN4-1:0]   r_umbral_low;
    logic [LEN4-1:0]   r_umbral_high;
    logic              r_vc0_wr;
    logic              r_vc1_wr;
    logic [BW-1:0]     r_vc_data;
    logic              r_idle;
    logic              r_error_out;

    // Next-state and pop decision
    always_comb begin
        w_err        = Main_error | VC0_error | VC1_error;
        w_next_state = r_state;
        w_rd         = 1'b0;
        case (r_state)
            ST_RESET: begin
                w_next_state = ST_INIT;
            end
            ST_INIT: begin
                if (!init) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (w_err) begin
                    w_next_state = ST_ERROR;
                end else if (init) begin
                    w_next_state = ST_INIT;
                end else if (!Main_empty) begin
                    w_next_state = ST_ACTIVE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                // Both VCs must have room because the destination is only known after the read.
                w_rd = !Main_empty && !VC0_almost_full && !VC1_almost_full && !init && !w_err;
                if (w_err) begin
                    w_next_state = ST_ERROR;
                end else if ((init || Main_empty) && !r_rd_q) begin
                    // Leave only once the last popped word has been captured.
                    w_next_state = init ? ST_INIT : ST_IDLE;
                end else begin
                    w_next_state = ST_ACTIVE;
                end
            end
            ST_ERROR: begin
                w_next_state = ST_ERROR;
            end
            default: begin
                // Illegal encodings are treated as a fault.
                w_next_state = ST_ERROR;
            end
        endcase
    end

    // State register and registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RESET;
            r_idle      <= 1'b0;
            r_error_out <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_idle      <= (w_next_state == ST_IDLE);
            r_error_out <= (w_next_state == ST_ERROR);
        end
    end

    // Threshold registers, loaded only while configuring
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_umbral_low  <= {LEN4{1'b0}};
            r_umbral_high <= {LEN4{1'b0}};
        end else if (r_state == ST_INIT) begin
            r_umbral_low  <= umbral_low_in;
            r_umbral_high <= umbral_high_in;
        end else begin
            r_umbral_low  <= r_umbral_low;
            r_umbral_high <= r_umbral_high;
        end
    end

    // Read-data routing pipeline; an in-flight word is dropped on entry to ERROR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_q    <= 1'b0;
            r_vc0_wr  <= 1'b0;
            r_vc1_wr  <= 1'b0;
            r_vc_data <= {BW{1'b0}};
        end else begin
            r_rd_q <= w_rd;
            if (w_next_state == ST_ERROR) begin
                r_vc0_wr <= 1'b0;
                r_vc1_wr <= 1'b0;
            end else if (r_rd_q) begin
                r_vc_data <= Main_data_out;
                r_vc0_wr  <= ~Main_data_out[VC_BIT];
                r_vc1_wr  <= Main_data_out[VC_BIT];
            end else begin
                r_vc0_wr <= 1'b0;
                r_vc1_wr <= 1'b0;
            end
        end
    end

    assign Main_rd       = w_rd;
    assign UmbralMF_LOW  = r_umbral_low;
    assign UmbralMF_HIGH = r_umbral_high;
    assign VC0_wr        = r_vc0_wr;
    assign VC1_wr        = r_vc1_wr;
    assign VC_data       = r_vc_data;
    assign state         = r_state;
    assign idle          = r_idle;
    assign error_out     = r_error_out;

endmodule

// File: tb/tb_main_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_main_fifo_ctrl
// Directed bench for main_fifo_ctrl. The bench plays the Main FIFO (a queue
// of words), keeps a behavioural model of the controller built from its
// observable rules, compares every DUT output against it each cycle, and
// pins the model with hand-computed literal expectations per scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_main_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [3:0] umbral_low_in;
    logic [3:0] umbral_high_in;
    logic       Main_empty;
    logic       Main_error;
    logic [5:0] Main_data_out;
    logic       VC0_almost_full;
    logic       VC1_almost_full;
    logic       VC0_error;
    logic       VC1_error;
    logic       Main_rd;
    logic [3:0] UmbralMF_LOW;
    logic [3:0] UmbralMF_HIGH;
    logic       VC0_wr;
    logic       VC1_wr;
    logic [5:0] VC_data;
    logic [2:0] state;
    logic       idle;
    logic       error_out;

    main_fifo_ctrl #(.BW(6), .LEN4(4), .VC_BIT(5)) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_low_in(umbral_low_in), .umbral_high_in(umbral_high_in),
        .Main_empty(Main_empty), .Main_error(Main_error), .Main_data_out(Main_data_out),
        .VC0_almost_full(VC0_almost_full), .VC1_almost_full(VC1_almost_full),
        .VC0_error(VC0_error), .VC1_error(VC1_error),
        .Main_rd(Main_rd), .UmbralMF_LOW(UmbralMF_LOW), .UmbralMF_HIGH(UmbralMF_HIGH),
        .VC0_wr(VC0_wr), .VC1_wr(VC1_wr), .VC_data(VC_data),
        .state(state), .idle(idle), .error_out(error_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Main FIFO contents as seen by the bench
    logic [5:0] fifo_q[$];
    // Observed VC writes: vc*256 + data
    int         wlog[$];
    int         rd_cnt, first_rd, last_rd, af_rd_cnt;
    logic       in_af;

    // Behavioural model
    int         m_state;
    logic [3:0] m_lo, m_hi;
    logic       m_wr0, m_wr1;
    logic [5:0] m_data;
    logic       m_inf_v;      // a word popped last cycle awaits capture
    logic [5:0] m_inf_w;
    logic       m_rd;
    logic       rd_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lo = 4'd0; m_hi = 4'd0;
        m_wr0 = 1'b0; m_wr1 = 1'b0; m_data = 6'd0;
        m_inf_v = 1'b0; m_inf_w = 6'd0;
    endtask

    // Model advance over one rising edge, using the inputs of the cycle just ended
    task automatic model_edge();
        logic err, nonempty, vbit;
        int   nxt;
        err      = Main_error | VC0_error | VC1_error;
        nonempty = (fifo_q.size() != 0);
        if (m_state == 0)      nxt = 1;
        else if (m_state == 1) nxt = init ? 1 : 2;
        else if (m_state == 2) nxt = err ? 4 : (init ? 1 : (nonempty ? 3 : 2));
        else if (m_state == 3) nxt = err ? 4 : (((init || !nonempty) && !m_inf_v) ? (init ? 1 : 2) : 3);
        else                   nxt = 4;
        if (m_state == 1) begin
            m_lo = umbral_low_in;
            m_hi = umbral_high_in;
        end
        if (nxt == 4 || !m_inf_v) begin
            m_wr0 = 1'b0; m_wr1 = 1'b0;
        end else begin
            vbit   = m_inf_w[5];
            m_data = m_inf_w;
            m_wr0  = !vbit;
            m_wr1  = vbit;
        end
        m_inf_v = m_rd;
        if (m_rd) m_inf_w = fifo_q[0];
        m_state = nxt;
    endtask

    // One clock: compare on the falling edge, advance model and FIFO on the rising edge
    task automatic step();
        @(negedge clk);
        m_rd = (m_state == 3) && (fifo_q.size() != 0) && !VC0_almost_full && !VC1_almost_full
               && !init && !(Main_error | VC0_error | VC1_error);
        chk("Main_rd",   {31'd0, Main_rd},   {31'd0, m_rd});
        chk("state",     {29'd0, state},     m_state);
        chk("idle",      {31'd0, idle},      {31'd0, (m_state == 2)});
        chk("error_out", {31'd0, error_out}, {31'd0, (m_state == 4)});
        chk("VC0_wr",    {31'd0, VC0_wr},    {31'd0, m_wr0});
        chk("VC1_wr",    {31'd0, VC1_wr},    {31'd0, m_wr1});
        chk("VC_data",   {26'd0, VC_data},   {26'd0, m_data});
        chk("UMF_LOW",   {28'd0, UmbralMF_LOW},  {28'd0, m_lo});
        chk("UMF_HIGH",  {28'd0, UmbralMF_HIGH}, {28'd0, m_hi});
        if (VC0_wr) wlog.push_back({26'd0, VC_data});
        if (VC1_wr) wlog.push_back(256 + {26'd0, VC_data});
        if (Main_rd) begin
            if (rd_cnt == 0) first_rd = cyc;
            last_rd = cyc;
            rd_cnt++;
            if (in_af) af_rd_cnt++;
        end
        rd_seen = Main_rd;
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
        if (rd_seen && fifo_q.size() != 0) Main_data_out = fifo_q.pop_front();
        Main_empty = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic clear_obs();
        wlog.delete();
        rd_cnt = 0; first_rd = 0; last_rd = 0; af_rd_cnt = 0;
    endtask

    task automatic push_word(input logic [5:0] w);
        fifo_q.push_back(w);
        Main_empty = 1'b0;
    endtask

    // Mid-cycle asynchronous reset with immediate output check
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        chk({tag, "_state"}, {29'd0, state}, 32'd0);
        chk({tag, "_rd"},    {31'd0, Main_rd}, 32'd0);
        chk({tag, "_wr"},    {30'd0, VC1_wr, VC0_wr}, 32'd0);
        chk({tag, "_data"},  {26'd0, VC_data}, 32'd0);
        chk({tag, "_thr"},   {24'd0, UmbralMF_HIGH, UmbralMF_LOW}, 32'd0);
        chk({tag, "_flags"}, {30'd0, idle, error_out}, 32'd0);
        model_reset();
        fifo_q.delete();
        Main_empty = 1'b1;
    endtask

    task automatic bring_up(input logic [3:0] lo, input logic [3:0] hi);
        reset = 1'b0; init = 1'b1;
        umbral_low_in = lo; umbral_high_in = hi;
        step();
        chk("up_state_init", {29'd0, state}, 32'd1);
        step();
        init = 1'b0;
        step();
        chk("up_state_idle", {29'd0, state}, 32'd2);
    endtask

    initial begin
        reset = 1'b1; init = 1'b0;
        umbral_low_in = 4'd0; umbral_high_in = 4'd0;
        Main_empty = 1'b1; Main_error = 1'b0; Main_data_out = 6'd0;
        VC0_almost_full = 1'b0; VC1_almost_full = 1'b0;
        VC0_error = 1'b0; VC1_error = 1'b0;
        in_af = 1'b0; m_rd = 1'b0; rd_seen = 1'b0;
        model_reset();
        clear_obs();

        // Reset and configuration
        step(); step();
        chk("rst_state", {29'd0, state}, 32'd0);
        bring_up(4'd2, 4'd6);
        chk("cfg_low",  {28'd0, UmbralMF_LOW},  32'd2);
        chk("cfg_high", {28'd0, UmbralMF_HIGH}, 32'd6);

        // Routing burst 0x05, 0x25, 0x01
        clear_obs();
        push_word(6'h05); push_word(6'h25); push_word(6'h01);
        for (int i = 0; i < 8; i++) step();
        chk("burst_rd_cnt",  rd_cnt, 32'd3);
        chk("burst_rd_span", last_rd - first_rd, 32'd2);
        chk("burst_nwr",     wlog.size(), 32'd3);
        chk("burst_w0",      wlog[0], 32'h005);
        chk("burst_w1",      wlog[1], 32'h125);
        chk("burst_w2",      wlog[2], 32'h001);
        chk("burst_state",   {29'd0, state}, 32'd2);

        // Backpressure: VC1 almost full for 3 cycles mid-burst
        clear_obs();
        push_word(6'h11); push_word(6'h32); push_word(6'h03);
        push_word(6'h24); push_word(6'h15); push_word(6'h36);
        step(); step();
        VC1_almost_full = 1'b1; in_af = 1'b1;
        step(); step(); step();
        VC1_almost_full = 1'b0; in_af = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("bp_rd_in_af", af_rd_cnt, 32'd0);
        chk("bp_rd_cnt",   rd_cnt, 32'd6);
        chk("bp_nwr",      wlog.size(), 32'd6);
        chk("bp_w0", wlog[0], 32'h011);
        chk("bp_w1", wlog[1], 32'h132);
        chk("bp_w2", wlog[2], 32'h003);
        chk("bp_w3", wlog[3], 32'h124);
        chk("bp_w4", wlog[4], 32'h015);
        chk("bp_w5", wlog[5], 32'h136);
        chk("bp_state", {29'd0, state}, 32'd2);

        // Error pulse during ACTIVE: second in-flight word is dropped
        clear_obs();
        push_word(6'h2A); push_word(6'h07); push_word(6'h08); push_word(6'h09);
        step(); step(); step();
        Main_error = 1'b1;
        step();
        Main_error = 1'b0;
        chk("err_flag",  {31'd0, error_out}, 32'd1);
        chk("err_state", {29'd0, state}, 32'd4);
        for (int i = 0; i < 4; i++) step();
        chk("err_sticky", {29'd0, state}, 32'd4);
        chk("err_nwr",    wlog.size(), 32'd1);
        chk("err_w0",     wlog[0], 32'h12A);
        do_reset("rst2");
        step();
        bring_up(4'd2, 4'd6);

        // Reconfigure during ACTIVE
        clear_obs();
        push_word(6'h21); push_word(6'h02); push_word(6'h23); push_word(6'h04); push_word(6'h25);
        step(); step(); step();
        init = 1'b1; umbral_low_in = 4'd3; umbral_high_in = 4'd9;
        step();
        chk("rcfg_hold_state", {29'd0, state}, 32'd3);
        step();
        chk("rcfg_state", {29'd0, state}, 32'd1);
        chk("rcfg_nwr",   wlog.size(), 32'd2);
        step();
        chk("rcfg_low",  {28'd0, UmbralMF_LOW},  32'd3);
        chk("rcfg_high", {28'd0, UmbralMF_HIGH}, 32'd9);
        init = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("rcfg_total", wlog.size(), 32'd5);
        chk("rcfg_w0", wlog[0], 32'h121);
        chk("rcfg_w1", wlog[1], 32'h002);
        chk("rcfg_w2", wlog[2], 32'h123);
        chk("rcfg_w3", wlog[3], 32'h004);
        chk("rcfg_w4", wlog[4], 32'h125);
        chk("rcfg_end_state", {29'd0, state}, 32'd2);

        // Reset during ACTIVE clears the strobes immediately
        push_word(6'h30); push_word(6'h11); push_word(6'h32);
        step(); step(); step();
        chk("pre_rst_vc1_wr", {31'd0, VC1_wr}, 32'd1);
        do_reset("rst3");
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
